// File: rtl/fire_pkg.sv
// -----------------------------------------------------------------------------
// fire_pkg
// Shared constants and types for the fire2/3 expand layer post-processing.
//   NUM_CH            channels per pixel (also bias table depth)
//   ACC_W             accumulator / bias width, signed two's complement
//   OUT_W             output activation width (signed, always >= 0)
//   FIRE23_EXP_SHIFT  requantisation right shift for this layer
// -----------------------------------------------------------------------------
package fire_pkg;

  localparam int NUM_CH           = 64;
  localparam int ACC_W            = 32;
  localparam int OUT_W            = 16;
  localparam int FIRE23_EXP_SHIFT = 4;
  localparam int CH_W             = $clog2(NUM_CH);
  // Two guard bits so acc + bias can never overflow.
  localparam int SUM_W            = ACC_W + 2;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic        [OUT_W-1:0] act_t;
  typedef logic        [CH_W-1:0]  ch_t;
  typedef logic signed [SUM_W-1:0] sum_t;

  // Sign-extend an accumulator-width value to the widened sum width.
  function automatic sum_t sext_acc(input acc_t v);
    return sum_t'(v);
  endfunction

endpackage : fire_pkg

// File: rtl/relu_round_sat.sv
// -----------------------------------------------------------------------------
// relu_round_sat
// Purely combinational requantisation datapath:
//   ReLU -> round-half-up -> arithmetic right shift by SHIFT -> saturate to
//   the largest positive OUT_W-bit signed value.
// Ports:
//   sum_i   in  SUM_W  signed biased accumulator
//   data_o  out OUT_W  requantised, non-negative activation
// -----------------------------------------------------------------------------
module relu_round_sat
  import fire_pkg::*;
#(
  parameter int SHIFT = FIRE23_EXP_SHIFT
) (
  input  sum_t sum_i,
  output act_t data_o
);

  localparam logic [SUM_W-1:0] MAX_POS = SUM_W'((64'd1 << (OUT_W-1)) - 64'd1);

  // After ReLU the value is non-negative, so it is carried unsigned; the
  // unsigned SUM_W range leaves headroom for the rounding constant.
  logic [SUM_W-1:0] relu_val;
  logic [SUM_W-1:0] rnd_val;

  always_comb begin
    relu_val = sum_i[SUM_W-1] ? '0 : $unsigned(sum_i);
  end

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic [SUM_W-1:0] HALF = SUM_W'(64'd1 << (SHIFT-1));
      // Logical shift equals arithmetic shift here because relu_val >= 0.
      always_comb begin
        rnd_val = (relu_val + HALF) >> SHIFT;
      end
    end else begin : g_noround
      always_comb begin
        rnd_val = relu_val;
      end
    end
  endgenerate

  always_comb begin
    data_o = (rnd_val > MAX_POS) ? MAX_POS[OUT_W-1:0] : rnd_val[OUT_W-1:0];
  end

endmodule : relu_round_sat

// File: rtl/bias_relu_requant.sv
// -----------------------------------------------------------------------------
// bias_relu_requant
// Post-MAC stage for the fire2/3 expand layer. Each accepted accumulator beat
// gets its channel's bias added (S1), then ReLU/round/shift/saturate (S2), and
// is forwarded over a valid/ready stream. Channels arrive in order
// 0..NUM_CH-1; a local counter tracks which channel each beat belongs to.
// Ports:
//   clk, rst_n   clock (rising edge), async active-low reset
//   bias_mem     per-channel bias table (static)
//   ch_clr       synchronous channel counter clear (resync)
//   in_valid/in_ready/in_acc      accumulator input stream
//   out_valid/out_ready/out_data  activation output stream
//   out_ch       channel of out_data, out_last marks channel NUM_CH-1
//   pix_cnt      count of completed pixels (last beats accepted), wraps
// -----------------------------------------------------------------------------
module bias_relu_requant
  import fire_pkg::*;
#(
  parameter int SHIFT = FIRE23_EXP_SHIFT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  acc_t        bias_mem [NUM_CH],
  input  logic        ch_clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  acc_t        in_acc,
  output logic        out_valid,
  input  logic        out_ready,
  output act_t        out_data,
  output ch_t         out_ch,
  output logic        out_last,
  output logic [15:0] pix_cnt
);

  localparam ch_t LAST_CH = ch_t'(NUM_CH - 1);

  // Goes high on the first clock after reset release; keeps in_ready low
  // while the block is held in reset.
  logic run_q;

  ch_t ch_cnt_q, ch_cnt_d;

  logic s1_v_q,   s1_v_d;
  sum_t s1_sum_q, s1_sum_d;
  ch_t  s1_ch_q,  s1_ch_d;

  logic s2_v_q,    s2_v_d;
  act_t s2_data_q, s2_data_d;
  ch_t  s2_ch_q,   s2_ch_d;
  logic s2_last_q, s2_last_d;

  logic [15:0] pix_cnt_q, pix_cnt_d;

  logic s2_adv;
  logic s1_adv;
  logic accept;
  ch_t  beat_ch;
  act_t s2_res;

  // Handshake: a stage may load when it is empty or its contents move on.
  always_comb begin
    s2_adv   = !s2_v_q || out_ready;
    s1_adv   = !s1_v_q || s2_adv;
    in_ready = run_q && s1_adv;
    accept   = in_valid && in_ready;
    // A resync beat is channel 0 regardless of the counter.
    beat_ch  = ch_clr ? '0 : ch_cnt_q;
  end

  relu_round_sat #(
    .SHIFT (SHIFT)
  ) u_relu_round_sat (
    .sum_i  (s1_sum_q),
    .data_o (s2_res)
  );

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    ch_cnt_d  = ch_cnt_q;
    s1_v_d    = s1_v_q;
    s1_sum_d  = s1_sum_q;
    s1_ch_d   = s1_ch_q;
    s2_v_d    = s2_v_q;
    s2_data_d = s2_data_q;
    s2_ch_d   = s2_ch_q;
    s2_last_d = s2_last_q;
    pix_cnt_d = pix_cnt_q;

    if (accept) begin
      ch_cnt_d = (beat_ch == LAST_CH) ? '0 : beat_ch + ch_t'(1);
    end else if (ch_clr) begin
      ch_cnt_d = '0;
    end

    if (s1_adv) begin
      s1_v_d = accept;
      if (accept) begin
        s1_sum_d = sext_acc(in_acc) + sext_acc(bias_mem[beat_ch]);
        s1_ch_d  = beat_ch;
      end
    end

    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_data_d = s2_res;
        s2_ch_d   = s1_ch_q;
        s2_last_d = (s1_ch_q == LAST_CH);
      end
    end

    if (s2_v_q && out_ready && s2_last_q) begin
      pix_cnt_d = pix_cnt_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q     <= 1'b0;
      ch_cnt_q  <= '0;
      s1_v_q    <= 1'b0;
      s1_sum_q  <= '0;
      s1_ch_q   <= '0;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      s2_ch_q   <= '0;
      s2_last_q <= 1'b0;
      pix_cnt_q <= '0;
    end else begin
      run_q     <= 1'b1;
      ch_cnt_q  <= ch_cnt_d;
      s1_v_q    <= s1_v_d;
      s1_sum_q  <= s1_sum_d;
      s1_ch_q   <= s1_ch_d;
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
      s2_ch_q   <= s2_ch_d;
      s2_last_q <= s2_last_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

  always_comb begin
    out_valid = s2_v_q;
    out_data  = s2_data_q;
    out_ch    = s2_ch_q;
    out_last  = s2_last_q;
    pix_cnt   = pix_cnt_q;
  end

endmodule : bias_relu_requant

// File: tb/tb_bias_relu_requant.sv
// -----------------------------------------------------------------------------
// tb_bias_relu_requant
// Randomised and directed stimulus against a transaction-level reference:
// each accepted beat is turned into an expected activation with plain integer
// arithmetic and queued; the output stream is compared in order.
// -----------------------------------------------------------------------------
module tb_bias_relu_requant;
  import fire_pkg::*;

  localparam int SHIFT = FIRE23_EXP_SHIFT;

  logic        clk = 1'b0;
  logic        rst_n;
  acc_t        bias_mem [NUM_CH];
  logic        ch_clr;
  logic        in_valid;
  logic        in_ready;
  acc_t        in_acc;
  logic        out_valid;
  logic        out_ready;
  act_t        out_data;
  ch_t         out_ch;
  logic        out_last;
  logic [15:0] pix_cnt;

  always #5 clk = ~clk;

  bias_relu_requant #(.SHIFT(SHIFT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bias_mem  (bias_mem),
    .ch_clr    (ch_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_acc    (in_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .pix_cnt   (pix_cnt)
  );

  typedef struct {
    int data;
    int ch;
    bit last;
    int want_data;  // test-plan constant, -1 if none
    int want_ch;    // test-plan constant, -1 if none
  } exp_t;

  exp_t exp_q[$];
  int   model_ch;
  int   exp_pix;
  int   n_acc;
  int   n_pass;
  int   n_checks;

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  // Reference requantisation straight from the arithmetic definition.
  function automatic int ref_act(input longint acc, input longint bias);
    longint s;
    longint lim;
    lim = (longint'(1) << (OUT_W - 1)) - 1;
    s   = acc + bias;
    if (s < 0) s = 0;
    if (SHIFT > 0) s = (s + (longint'(1) << (SHIFT - 1))) / (longint'(1) << SHIFT);
    if (s > lim) s = lim;
    return int'(s);
  endfunction

  function automatic acc_t rnd_acc();
    case ($urandom_range(3))
      0:       return acc_t'(int'($urandom_range(8192)) - 4096);
      1:       return acc_t'(int'($urandom_range(2000000)) - 1000000);
      2:       return acc_t'($urandom);
      default: return acc_t'(524000 + int'($urandom_range(600)));  // near saturation
    endcase
  endfunction

  // One clock: drive at negedge, observe 1 ns later, then wait for posedge.
  task automatic cycle(input bit v, input acc_t acc, input bit clr, input bit ordy,
                       input int want_data = -1, input int want_ch = -1);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    in_acc    = acc;
    ch_clr    = clr;
    out_ready = ordy;
    #1;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("out_valid_unexpected", 1, 0);
      end else begin
        e = exp_q[0];
        check("out_data", out_data, e.data);
        check("out_ch", out_ch, e.ch);
        check("out_last", out_last, e.last);
        if (out_ready) begin
          void'(exp_q.pop_front());
          if (e.want_data >= 0) check("tp_data", out_data, e.want_data);
          if (e.want_ch >= 0) check("tp_ch", out_ch, e.want_ch);
          if (e.last) exp_pix = (exp_pix + 1) % 65536;
        end
      end
    end
    if (in_valid && in_ready) begin
      int c;
      c           = clr ? 0 : model_ch;
      e.data      = ref_act(longint'(acc), longint'(bias_mem[c]));
      e.ch        = c;
      e.last      = (c == NUM_CH - 1);
      e.want_data = want_data;
      e.want_ch   = want_ch;
      exp_q.push_back(e);
      model_ch = (c + 1) % NUM_CH;
      n_acc++;
    end else if (clr) begin
      model_ch = 0;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic drain();
    int budget;
    budget = 50;
    while (exp_q.size() != 0 && budget > 0) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      budget--;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    idle(1);
  endtask

  initial begin
    int a0;
    n_pass   = 0;
    n_checks = 0;
    n_acc    = 0;
    model_ch = 0;
    exp_pix  = 0;

    for (int i = 0; i < NUM_CH; i++) bias_mem[i] = acc_t'(int'($urandom_range(4000)) - 2000);
    bias_mem[0]  = 386;
    bias_mem[3]  = 666;
    bias_mem[4]  = -22;
    bias_mem[63] = 1114;

    rst_n     = 1'b0;
    ch_clr    = 1'b0;
    in_valid  = 1'b0;
    in_acc    = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_out_last", out_last, 0);
    check("rst_pix_cnt", pix_cnt, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // First beat: ch0, acc 0, two-cycle latency
    cycle(1'b1, '0, 1'b0, 1'b1, 24, 0);
    #1 check("lat_cycle1_valid", out_valid, 0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    #1 check("lat_cycle2_valid", out_valid, 1);
    check("first_out_data", out_data, 24);
    drain();

    // ReLU zero, saturation, small rounding case
    cycle(1'b1, rnd_acc(), 1'b0, 1'b1);                 // ch1
    cycle(1'b1, rnd_acc(), 1'b0, 1'b1);                 // ch2
    cycle(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 32767, 3);   // ch3 saturates
    cycle(1'b1, -32'sd1000, 1'b0, 1'b1, 0, 4);          // ch4 negative -> 0
    cycle(1'b1, rnd_acc(), 1'b1, 1'b1, -1, 0);          // resync to ch0
    for (int i = 0; i < 3; i++) cycle(1'b1, rnd_acc(), 1'b0, 1'b1);
    cycle(1'b1, 32'sd30, 1'b0, 1'b1, 1, 4);             // sum 8 -> 1
    drain();

    // 130 back-to-back beats
    a0 = n_acc;
    for (int i = 0; i < 130; i++) begin
      if (i == 63) cycle(1'b1, '0, 1'b0, 1'b1, 70, 63);
      else         cycle(1'b1, rnd_acc(), (i == 0), 1'b1, -1, i % NUM_CH);
    end
    check("throughput_accepts", n_acc - a0, 130);
    drain();
    check("pix_after_130", pix_cnt, 2);

    // Backpressure: out_ready low for 5 cycles with continuous input
    a0 = n_acc;
    for (int i = 0; i < 5; i++) cycle(1'b1, rnd_acc(), 1'b0, 1'b0);
    check("stall_accepts", n_acc - a0, 2);
    #1 check("stall_in_ready", in_ready, 0);
    for (int i = 0; i < 20; i++) cycle(1'b1, rnd_acc(), 1'b0, 1'b1);
    drain();

    // Random traffic with random backpressure and occasional resync
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(3) != 0, rnd_acc(), $urandom_range(39) == 0, $urandom_range(2) != 0);
    drain();
    check("pix_after_random", pix_cnt, exp_pix);

    // Resync at counter 17
    cycle(1'b1, rnd_acc(), 1'b1, 1'b1, -1, 0);
    for (int i = 1; i < 17; i++) cycle(1'b1, rnd_acc(), 1'b0, 1'b1, -1, i);
    cycle(1'b1, rnd_acc(), 1'b1, 1'b1, -1, 0);
    cycle(1'b1, rnd_acc(), 1'b0, 1'b1, -1, 1);
    drain();

    // Reset with both stages full
    cycle(1'b1, rnd_acc(), 1'b0, 1'b0);
    cycle(1'b1, rnd_acc(), 1'b0, 1'b0);
    #1 check("pre_rst_out_valid", out_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_pix_cnt", pix_cnt, 0);
    check("mid_rst_in_ready", in_ready, 0);
    exp_q.delete();
    model_ch = 0;
    exp_pix  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check("post_rst_out_valid", out_valid, 0);
    cycle(1'b1, rnd_acc(), 1'b0, 1'b1, -1, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_bias_relu_requant
